// File: rtl/spi_flash_reader.sv
// Purpose: turns one (addr,len) request into a READ 0x03 flash transaction on the spi transceiver and a byte stream.
// Latency: accept -> first spi_start after 2 clocks; captured byte -> out_valid after 1 clock.
// Backpressure: out_valid holds until out_ready; no new spi_start is issued while a byte is undelivered.
module spi_flash_reader #(
   parameter logic [7:0] CMD_READ = 8'h03,
   parameter int         LEN_W    = 16,
   parameter int         CS_GAP   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [23:0]      req_addr,
   input  logic [LEN_W-1:0] req_len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic             spi_start,
   output logic             spi_fast,
   output logic [31:0]      spi_dataTx,
   input  logic [31:0]      spi_dataRx,
   input  logic             spi_rdy,
   output logic             flash_cs_n
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_ISSUE,
      ST_WAIT,
      ST_DELIVER,
      ST_CS_GAP,
      ST_DONE
   } state_t;

   // Phases 0..3 are opcode and address bytes; phase 4 is every data byte.
   localparam logic [2:0] PH_DATA = 3'd4;
   localparam int         GAP_W   = $clog2(CS_GAP + 1);

   state_t           state;
   logic [23:0]      addr_q;
   logic [LEN_W-1:0] remaining;
   logic [2:0]       phase;
   logic             wait_skip;
   logic [7:0]       tx_byte;
   logic [GAP_W-1:0] gap_cnt;

   // Only the low byte of the transceiver word carries flash data.
   logic unused_rx_hi;
   assign unused_rx_hi = ^spi_dataRx[31:8];

   // Byte mode only; upper transmit bits are always zero.
   assign spi_fast   = 1'b0;
   assign spi_dataTx = {24'h0, tx_byte};

   // Byte shifted out for a given phase: opcode, address MSB first, then dummy 0xFF.
   function automatic logic [7:0] phase_byte(input logic [2:0] ph, input logic [23:0] a);
      logic [7:0] b;
      b = 8'hFF;
      case (ph)
         3'd0:    b = CMD_READ;
         3'd1:    b = a[23:16];
         3'd2:    b = a[15:8];
         3'd3:    b = a[7:0];
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

   // Request sequencer: chip select framing, spi byte issue, byte delivery and completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b1;
         addr_q     <= 24'h0;
         remaining  <= '0;
         phase      <= 3'd0;
         wait_skip  <= 1'b0;
         tx_byte    <= 8'h0;
         gap_cnt    <= '0;
         out_valid  <= 1'b0;
         out_data   <= 8'h0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         spi_start  <= 1'b0;
         flash_cs_n <= 1'b1;
      end else begin
         spi_start <= 1'b0;
         done      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  addr_q    <= req_addr;
                  remaining <= req_len;
                  phase     <= 3'd0;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  // A zero-length request completes without touching the flash.
                  if (req_len == '0) begin
                     state <= ST_DONE;
                  end else begin
                     flash_cs_n <= 1'b0;
                     state      <= ST_CS_SETUP;
                  end
               end
            end
            ST_CS_SETUP: begin
               state <= ST_ISSUE;
            end
            ST_ISSUE: begin
               // out_valid is always low here; the term keeps overwrite impossible by construction.
               if (spi_rdy && !out_valid) begin
                  spi_start <= 1'b1;
                  tx_byte   <= phase_byte(phase, addr_q);
                  wait_skip <= 1'b1;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // spi_rdy is still high in the cycle the start pulse is visible; ignore that cycle.
               if (wait_skip) begin
                  wait_skip <= 1'b0;
               end else if (spi_rdy) begin
                  if (phase != PH_DATA) begin
                     phase <= phase + 3'd1;
                     state <= ST_ISSUE;
                  end else begin
                     out_data  <= spi_dataRx[7:0];
                     out_valid <= 1'b1;
                     out_last  <= (remaining == LEN_W'(1));
                     remaining <= remaining - LEN_W'(1);
                     state     <= ST_DELIVER;
                  end
               end
            end
            ST_DELIVER: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (remaining != '0) begin
                     state <= ST_ISSUE;
                  end else begin
                     flash_cs_n <= 1'b1;
                     gap_cnt    <= GAP_W'(CS_GAP - 1);
                     state      <= ST_CS_GAP;
                  end
               end
            end
            ST_CS_GAP: begin
               // Chip select stays high for CS_GAP cycles before the request may complete.
               if (gap_cnt == '0) begin
                  state <= ST_DONE;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            ST_DONE: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural spi transceiver + flash, scoreboard of MOSI bytes and output bytes.
// Stimulus pushes expectations on request acceptance; a negedge monitor pops and compares.
// Directed cases: basic read, zero length, long stall, back-to-back, ignored request, reset mid-transfer.
module tb_spi_flash_reader;

   localparam int LEN_W  = 16;
   localparam int CS_GAP = 4;
   localparam int XFER   = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [23:0]      req_addr;
   logic [LEN_W-1:0] req_len;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic             out_last;
   logic             busy;
   logic             done;
   logic             spi_start;
   logic             spi_fast;
   logic [31:0]      spi_dataTx;
   logic [31:0]      spi_dataRx;
   logic             spi_rdy;
   logic             flash_cs_n;

   always #5 clk = ~clk;

   spi_flash_reader #(.CMD_READ(8'h03), .LEN_W(LEN_W), .CS_GAP(CS_GAP)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done),
      .spi_start(spi_start), .spi_fast(spi_fast), .spi_dataTx(spi_dataTx),
      .spi_dataRx(spi_dataRx), .spi_rdy(spi_rdy), .flash_cs_n(flash_cs_n)
   );

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int exp_done = 0;
   int start_cnt = 0;
   int hs_cnt = 0;
   logic [7:0] exp_mosi[$];
   logic [8:0] exp_out[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Flash contents: a fixed scramble of the byte address.
   function automatic logic [7:0] fmem(input logic [23:0] a);
      return a[7:0] ^ {a[14:8], a[15]} ^ a[23:16] ^ 8'h5A;
   endfunction

   // Transceiver + flash: a start (seen with cs low) makes rdy drop for XFER cycles, then rdy rises with the reply byte.
   initial begin
      logic st, cs;
      logic [7:0] tx, resp;
      logic [23:0] maddr;
      int cnt, idx;
      spi_rdy = 1'b1; spi_dataRx = 32'h0; cnt = 0; idx = 0; maddr = 24'h0; resp = 8'h0;
      forever begin
         @(negedge clk);
         st = spi_start; cs = flash_cs_n; tx = spi_dataTx[7:0];
         if (cs && !st) idx = 0;
         @(posedge clk); #1;
         if (!rst) begin
            spi_rdy = 1'b1; cnt = 0; idx = 0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               spi_rdy = 1'b1;
               spi_dataRx = {24'h0, resp};
            end
         end else if (st) begin
            chk("cs_low_at_start", {31'h0, cs}, 32'h0);
            start_cnt++;
            case (idx)
               1: maddr[23:16] = tx;
               2: maddr[15:8]  = tx;
               3: maddr[7:0]   = tx;
               default: ;
            endcase
            resp = (idx < 4) ? 8'hEE : fmem(maddr + 24'(idx - 4));
            idx++;
            spi_rdy = 1'b0;
            cnt = XFER;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a start or a byte handshake; checks invariants.
   initial begin
      logic prev_stall, plast, prev_cs, had_low, prev_done;
      logic [7:0] pdat, m;
      logic [8:0] e;
      int gap;
      prev_stall = 0; plast = 0; pdat = 0; prev_cs = 1; had_low = 0; prev_done = 0; gap = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_stall = 0; prev_done = 0; had_low = 0; prev_cs = 1; gap = 0;
         end else begin
            if (spi_start) begin
               if (exp_mosi.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL mosi_unexpected: start with tx %h, none expected (t=%0t)", spi_dataTx, $time);
               end else begin
                  m = exp_mosi.pop_front();
                  chk("mosi_byte", spi_dataTx, {24'h0, m});
               end
               chk("start_while_out_valid", {31'h0, out_valid}, 32'h0);
            end
            if (out_valid && out_ready) begin
               hs_cnt++;
               if (exp_out.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL out_unexpected: byte %h last %b, none expected (t=%0t)", out_data, out_last, $time);
               end else begin
                  e = exp_out.pop_front();
                  chk("out_last_data", {23'h0, out_last, out_data}, {23'h0, e});
               end
               if (prev_stall) chk("out_hold_at_hs", {23'h0, out_last, out_data}, {23'h0, plast, pdat});
               prev_stall = 0;
            end else if (out_valid) begin
               if (prev_stall) chk("out_stable", {23'h0, out_last, out_data}, {23'h0, plast, pdat});
               prev_stall = 1; pdat = out_data; plast = out_last;
            end else begin
               prev_stall = 0;
            end
            if (done) begin
               done_cnt++;
               chk("done_one_cycle", {31'h0, prev_done}, 32'h0);
            end
            prev_done = done;
            if (busy) chk("req_ready_low_while_busy", {31'h0, req_ready}, 32'h0);
            if (flash_cs_n) begin
               gap++;
            end else begin
               if (prev_cs && had_low) chk("cs_gap_min", {31'h0, (gap >= CS_GAP)}, 32'h1);
               had_low = 1; gap = 0;
            end
            prev_cs = flash_cs_n;
         end
      end
   end

   // Present a request and wait (bounded) for its acceptance; expectations are queued at the accept edge.
   task automatic do_req(input logic [23:0] a, input int len, input bit keep);
      bit acc;
      acc = 0;
      req_addr = a; req_len = LEN_W'(len); req_valid = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (req_ready) begin acc = 1; break; end
      end
      if (!acc) begin
         n_cmp++; n_err++;
         $display("FAIL req_accept_timeout: addr %h not accepted", a);
      end
      @(posedge clk); #1;
      if (len > 0) begin
         exp_mosi.push_back(8'h03);
         exp_mosi.push_back(a[23:16]);
         exp_mosi.push_back(a[15:8]);
         exp_mosi.push_back(a[7:0]);
         for (int i = 0; i < len; i++) begin
            exp_mosi.push_back(8'hFF);
            exp_out.push_back({(i == len - 1), fmem(a + 24'(i))});
         end
      end
      exp_done++;
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_all(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #2;
         if (done_cnt == exp_done && !busy) break;
      end
      chk("done_count", done_cnt, exp_done);
      chk("busy_idle", {31'h0, busy}, 32'h0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, d, base;
      rst = 1'b0; req_valid = 1'b0; req_addr = 24'h0; req_len = '0; out_ready = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", {31'h0, flash_cs_n}, 32'h1);
      chk("rst_spi_start", {31'h0, spi_start}, 32'h0);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_out_data", {24'h0, out_data}, 32'h0);
      chk("rst_out_last", {31'h0, out_last}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      @(posedge clk); #3 rst = 1'b1;
      @(posedge clk); #1;
      chk("req_ready_after_rst", {31'h0, req_ready}, 32'h1);
      chk("spi_fast_tied", {31'h0, spi_fast}, 32'h0);

      // Basic read of 4 bytes; accept -> first start is 2 clocks
      do_req(24'h012345, 4, 0);
      chk("busy_on_accept", {31'h0, busy}, 32'h1);
      chk("req_ready_on_accept", {31'h0, req_ready}, 32'h0);
      chk("cs_low_on_accept", {31'h0, flash_cs_n}, 32'h0);
      chk("start_lat_0", {31'h0, spi_start}, 32'h0);
      @(posedge clk); #1;
      chk("start_lat_1", {31'h0, spi_start}, 32'h0);
      @(posedge clk); #1;
      chk("start_lat_2", {31'h0, spi_start}, 32'h1);
      wait_all(2000);

      // Zero length: DONE state after accept edge, done pulse on the following edge, no flash traffic
      s = start_cnt;
      do_req(24'h00AAAA, 0, 0);
      chk("len0_done_early", {31'h0, done}, 32'h0);
      chk("len0_cs_n_a", {31'h0, flash_cs_n}, 32'h1);
      @(posedge clk); #1;
      chk("len0_done", {31'h0, done}, 32'h1);
      chk("len0_cs_n_b", {31'h0, flash_cs_n}, 32'h1);
      @(posedge clk); #1;
      chk("len0_done_end", {31'h0, done}, 32'h0);
      chk("len0_req_ready", {31'h0, req_ready}, 32'h1);
      chk("len0_no_start", start_cnt, s);
      wait_all(100);

      // Consumer stalls 1000 cycles after the first byte
      out_ready = 1'b0;
      do_req(24'h00ABCD, 3, 0);
      for (int i = 0; i < 500; i++) begin
         @(posedge clk); #2;
         if (out_valid) break;
      end
      chk("stall_first_valid", {31'h0, out_valid}, 32'h1);
      s = start_cnt;
      repeat (1000) @(posedge clk);
      #2;
      chk("stall_no_start", start_cnt, s);
      chk("stall_spi_idle", {31'h0, spi_rdy}, 32'h1);
      chk("stall_still_valid", {31'h0, out_valid}, 32'h1);
      out_ready = 1'b1;
      wait_all(2000);

      // Back-to-back with req_valid held across the first request
      do_req(24'h100000, 2, 1);
      do_req(24'h200010, 3, 0);
      wait_all(3000);

      // req_valid pulsed while busy is ignored
      do_req(24'h0000F0, 4, 0);
      repeat (5) @(posedge clk);
      #1 req_addr = 24'h777777; req_len = LEN_W'(5); req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      wait_all(3000);
      d = done_cnt; s = start_cnt;
      repeat (50) @(posedge clk);
      #2;
      chk("ignored_no_done", done_cnt, d);
      chk("ignored_no_start", start_cnt, s);

      // Reset during data byte 2 of an 8-byte read
      base = hs_cnt;
      do_req(24'h030000, 8, 0);
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk); #2;
         if (hs_cnt == base + 1) break;
      end
      chk("abort_first_byte", hs_cnt, base + 1);
      @(posedge clk); #3 rst = 1'b0;
      #1;
      chk("abort_cs_n", {31'h0, flash_cs_n}, 32'h1);
      chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_done", {31'h0, done}, 32'h0);
      exp_mosi.delete();
      exp_out.delete();
      exp_done--;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      do_req(24'h000010, 1, 0);
      wait_all(1000);

      chk("mosi_queue_empty", exp_mosi.size(), 0);
      chk("out_queue_empty", exp_out.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
